// File: rtl/bram_port_arbiter.sv
// Shares one port of a 16Kx1 dual-port block RAM between two same-clock requesters.
// Fixed priority to requester 0, with a starvation guard that eventually forces a requester 1 grant.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  REQ0,
    input  logic                  WE0,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [DATA_WIDTH-1:0] DI0,
    output logic                  ACK0,
    output logic [DATA_WIDTH-1:0] DO0,
    output logic                  DO_VLD0,

    input  logic                  REQ1,
    input  logic                  WE1,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] DI1,
    output logic                  ACK1,
    output logic [DATA_WIDTH-1:0] DO1,
    output logic                  DO_VLD1,

    output logic                  RAM_EN,
    output logic                  RAM_WE,
    output logic                  RAM_SSR,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_DI,
    input  logic [DATA_WIDTH-1:0] RAM_DO
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [3:0] STARVE_MAX = 4'hF;

    logic [3:0]            starve_cnt;
    logic                  force1;
    logic                  xfer;
    logic                  win1;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_di;

    logic                  s1_rd;
    logic                  s1_own;
    logic                  s2_rd;
    logic                  s2_own;

    // Grants are masked during reset so no requester sees an accept it cannot complete.
    always_comb begin
        force1 = !RST && REQ1 && (starve_cnt >= STARVE_LIM);
        ACK1   = !RST && REQ1 && (!REQ0 || force1);
        ACK0   = !RST && REQ0 && !force1;
        xfer   = ACK0 || ACK1;
        win1   = ACK1;
    end

    always_comb begin
        cmd_we   = WE0;
        cmd_addr = ADDR0;
        cmd_di   = DI0;
        if (win1) begin
            cmd_we   = WE1;
            cmd_addr = ADDR1;
            cmd_di   = DI1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (ACK1 || !REQ1) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Address and data hold on idle cycles so the RAM port does not toggle needlessly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RAM_EN   <= 1'b0;
            RAM_WE   <= 1'b0;
            RAM_ADDR <= '0;
            RAM_DI   <= '0;
        end else if (xfer) begin
            RAM_EN   <= 1'b1;
            RAM_WE   <= cmd_we;
            RAM_ADDR <= cmd_addr;
            RAM_DI   <= cmd_di;
        end else begin
            RAM_EN   <= 1'b0;
            RAM_WE   <= 1'b0;
        end
    end

    assign RAM_SSR = 1'b0;

    // Stage 1 tracks the command sitting on the RAM pins, stage 2 the one the RAM is reading.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_rd  <= 1'b0;
            s1_own <= 1'b0;
            s2_rd  <= 1'b0;
            s2_own <= 1'b0;
        end else begin
            s1_rd  <= xfer && !cmd_we;
            s1_own <= win1;
            s2_rd  <= s1_rd;
            s2_own <= s1_own;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DO0     <= '0;
            DO1     <= '0;
            DO_VLD0 <= 1'b0;
            DO_VLD1 <= 1'b0;
        end else begin
            DO_VLD0 <= s2_rd && !s2_own;
            DO_VLD1 <= s2_rd && s2_own;
            if (s2_rd && !s2_own) begin
                DO0 <= RAM_DO;
            end
            if (s2_rd && s2_own) begin
                DO1 <= RAM_DO;
            end
        end
    end

    ack_exclusive: assert property (@(posedge CLK) disable iff (RST) !(ACK0 && ACK1));
    vld_exclusive: assert property (@(posedge CLK) disable iff (RST) !(DO_VLD0 && DO_VLD1));

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of the 16Kx1 dual-port block RAM between two requesters (req0 = high priority, req1 = low priority).
- Arbitration is fixed-priority with a starvation guard that forces a grant to req1 after a programmable wait.
- RAM command outputs are registered. Read data is routed back to the owning requester with a valid strobe.
- Sits between the RAM port (EN/WE/ADDR/DI/DO/SSR) and two client engines in the same clock domain.

Parameters:
- ADDR_WIDTH, 14, RAM address width (16K x 1 organisation).
- DATA_WIDTH, 1, RAM data width.
- STARVE_LIMIT, 4, consecutive denied cycles of req1 that force a req1 grant (legal range 1..15).

Ports:
- CLK  input  1  single clock for the block and the attached RAM port.
- RST  input  1  asynchronous, active-high reset.
- REQ0  input  1  requester 0 command valid.
- WE0  input  1  requester 0 write (1) / read (0).
- ADDR0  input  ADDR_WIDTH  requester 0 address.
- DI0  input  DATA_WIDTH  requester 0 write data.
- ACK0  output  1  combinational; REQ0 accepted at this rising edge.
- DO0  output  DATA_WIDTH  requester 0 read data (registered).
- DO_VLD0  output  1  DO0 valid, one-cycle pulse per accepted read.
- REQ1, WE1, ADDR1, DI1, ACK1, DO1, DO_VLD1: same roles for requester 1.
- RAM_EN  output  1  RAM port enable (registered).
- RAM_WE  output  1  RAM port write enable (registered).
- RAM_SSR  output  1  RAM synchronous set/reset; held 0.
- RAM_ADDR  output  ADDR_WIDTH  RAM address (registered).
- RAM_DI  output  DATA_WIDTH  RAM write data (registered).
- RAM_DO  input  DATA_WIDTH  RAM read data, valid the cycle after the RAM samples EN.

Behaviour:
- Handshake (valid/ready): a transfer occurs at a rising edge where REQx=1 and ACKx=1.
  - A requester holds WEx/ADDRx/DIx stable while REQx=1 and ACKx=0.
  - ACK0 and ACK1 are never both 1.
  - Throughput is one command per cycle.
- Grant rule, combinational from REQ0, REQ1 and starve_cnt:
  - force1 = REQ1 && (starve_cnt >= STARVE_LIMIT).
  - ACK1 = REQ1 && (!REQ0 || force1).
  - ACK0 = REQ0 && !force1.
- starve_cnt (4 bits, saturating at 15), updated at each edge:
  - Cleared when ACK1=1 or REQ1=0.
  - Incremented when REQ1=1 and ACK1=0.
- Issue stage, edge k with a transfer:
  - RAM_EN <= 1; RAM_WE, RAM_ADDR, RAM_DI <= the winner's WE/ADDR/DI.
  - With no transfer: RAM_EN <= 0, RAM_WE <= 0, RAM_ADDR and RAM_DI hold their values.
- Return pipeline: two stages of {rd, owner}.
  - Stage 1 is loaded at edge k with rd = transfer && !WE, owner = winner.
  - Stage 2 is loaded at edge k+1; the RAM samples the command at edge k+1.
  - At edge k+2: DOowner <= RAM_DO and DO_VLDowner <= 1. All other DO_VLD outputs go to 0. DO of the non-owner holds.
  - Read latency is 2 edges from the accepting edge to the DO_VLD cycle. Writes produce no DO_VLD.
  - Back-to-back reads return in issue order, one per cycle, with no bubble.
- Reset (asynchronous, any time):
  - RAM_EN=0, RAM_WE=0, RAM_SSR=0, RAM_ADDR=0, RAM_DI=0.
  - DO0=DO1=0, DO_VLD0=DO_VLD1=0, starve_cnt=0, both pipeline stages invalid.
  - Reads in flight at reset are dropped; no DO_VLD follows the release of reset.
  - ACKx stays 0 while RST=1.
- Simultaneous requests: requester 0 wins unless force1. After a forced req1 grant the counter clears, so req0 regains priority the next cycle.
- Same-address write by one requester and read by the other in consecutive cycles: the ordering is the issue order. The RAM write mode defines the data seen.
- No buffering inside the block; back-pressure comes only through ACK.

Test Plan:
- Reset mid-read: REQ0=1 WE0=0 ADDR0=0x0005 accepted, RST pulsed the next cycle → DO_VLD0 never asserts; all outputs 0 during reset.
- Single read: RAM preloaded with bit 0x1234=1; REQ0 read 0x1234 → ACK0=1 at edge k; RAM_EN=1, RAM_ADDR=0x1234 after k; DO0=1 with DO_VLD0=1 for exactly one cycle after edge k+2.
- Write then read: req1 writes DI1=1 to 0x3FFF, then req1 reads 0x3FFF → DO_VLD1 pulse with DO1=1; no DO_VLD0 activity.
- Starvation: REQ0 and REQ1 held high continuously, STARVE_LIMIT=4 → grant pattern 0,0,0,0,1,0,0,0,0,1…; ACK0 and ACK1 never high together.
- Pipelined reads: req0 issues reads of 0x0000..0x0007 on 8 consecutive edges against a known pattern → 8 consecutive DO_VLD0 cycles with data in address order.
- Interleaved owners: alternate the accepted reads req0 0x0010, req1 0x0011, req0 0x0012 → DO_VLD0, DO_VLD1, DO_VLD0 in consecutive cycles with the matching data.
